// File: rtl/rename_pkg.sv
// Purpose: shared defaults and index types for the register-rename slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rename_pkg;

  localparam int ARCH_REGS_DEF  = 8;
  localparam int PHYS_REGS_DEF  = 16;
  localparam int READ_PORTS_DEF = 2;

  typedef logic [$clog2(ARCH_REGS_DEF)-1:0] arch_idx_t;
  typedef logic [$clog2(PHYS_REGS_DEF)-1:0] phys_idx_t;

endpackage

// File: rtl/lowest_free.sv
// Purpose: priority encoder returning the lowest-index clear bit of the claimed vector.
// Latency: combinational.
// Backpressure: none; found = 0 tells the caller no register is free.
// Ports: claimed (bit set = register in use) -> index (lowest clear bit), found.
module lowest_free #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] claimed,
  output logic [W-1:0] index,
  output logic         found
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!claimed[i]) begin
        index = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_map_unit.sv
// Purpose: speculative/committed register rename maps with a claimed-bit free list.
// Latency: lookups and alloc results combinational; all state updates on the next edge.
// Backpressure: alloc_ready drops when no register is free or flush is high; request must hold.
// Ports: clk/rst; read_arch/read_ena_in -> read_phys/read_ena_out (source lookup);
//        alloc_valid/alloc_arch -> alloc_ready/alloc_phys/alloc_old_phys (destination rename);
//        retire_valid/arch/phys/old_phys (commit + free); flush (restore committed map); free_count.
module rename_map_unit
  import rename_pkg::*;
#(
  parameter  int ARCH_REGS  = ARCH_REGS_DEF,
  parameter  int PHYS_REGS  = PHYS_REGS_DEF,
  parameter  int READ_PORTS = READ_PORTS_DEF,
  localparam int AW         = $clog2(ARCH_REGS),
  localparam int PW         = $clog2(PHYS_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [READ_PORTS-1:0][AW-1:0] read_arch,
  input  logic [READ_PORTS-1:0]        read_ena_in,
  output logic [READ_PORTS-1:0][PW-1:0] read_phys,
  output logic [READ_PORTS-1:0]        read_ena_out,
  input  logic                         alloc_valid,
  input  logic [AW-1:0]                alloc_arch,
  output logic                         alloc_ready,
  output logic [PW-1:0]                alloc_phys,
  output logic [PW-1:0]                alloc_old_phys,
  input  logic                         retire_valid,
  input  logic [AW-1:0]                retire_arch,
  input  logic [PW-1:0]                retire_phys,
  input  logic [PW-1:0]                retire_old_phys,
  input  logic                         flush,
  output logic [PW:0]                  free_count
);

  localparam int CW = PW + 1;

  logic [ARCH_REGS-1:0][PW-1:0] spec_map, spec_nxt;
  logic [ARCH_REGS-1:0][PW-1:0] commit_map, commit_nxt;
  logic [PHYS_REGS-1:0]         claimed, claimed_nxt;
  logic [CW-1:0]                count_nxt;

  logic [PW-1:0] low_idx;
  logic          low_found;
  logic          alloc_take;
  logic          alloc_fire;
  logic          retire_clr;

  lowest_free #(.N(PHYS_REGS), .W(PW)) u_lowest_free (
    .claimed (claimed),
    .index   (low_idx),
    .found   (low_found)
  );

  // Ready comes from the encoder, not free_count; free_count is only a cross-check.
  assign alloc_ready = low_found && !flush;
  assign alloc_take  = alloc_valid && alloc_ready;
  assign alloc_fire  = alloc_take && ena;

  assign alloc_phys     = alloc_take ? low_idx : '0;
  assign alloc_old_phys = alloc_take ? spec_map[alloc_arch] : '0;

  // Freeing a register that is not claimed is dropped so the free list stays consistent.
  assign retire_clr = retire_valid && claimed[retire_old_phys];

  // Lookups see the map before this cycle's allocation lands.
  always_comb begin
    read_phys = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      if (read_ena_in[k]) read_phys[k] = spec_map[read_arch[k]];
    end
  end

  assign read_ena_out = read_ena_in;

  always_comb begin
    commit_nxt = commit_map;
    if (retire_valid) commit_nxt[retire_arch] = retire_phys;

    spec_nxt    = spec_map;
    claimed_nxt = claimed;
    count_nxt   = free_count;

    if (flush) begin
      // Rebuild everything from the committed map including a same-cycle retire.
      spec_nxt    = commit_nxt;
      claimed_nxt = '0;
      for (int i = 0; i < ARCH_REGS; i++) claimed_nxt[commit_nxt[i]] = 1'b1;
      count_nxt = CW'(PHYS_REGS);
      for (int i = 0; i < PHYS_REGS; i++) count_nxt = count_nxt - CW'(claimed_nxt[i]);
    end else begin
      // alloc picks an unclaimed register and retire frees a claimed one, so they never collide.
      if (alloc_fire) begin
        claimed_nxt[low_idx]  = 1'b1;
        spec_nxt[alloc_arch]  = low_idx;
      end
      if (retire_clr) claimed_nxt[retire_old_phys] = 1'b0;
      count_nxt = free_count - CW'(alloc_fire) + CW'(retire_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_map[i]   <= PW'(i);
        commit_map[i] <= PW'(i);
      end
      claimed    <= {{(PHYS_REGS - ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
      free_count <= CW'(PHYS_REGS - ARCH_REGS);
    end else begin
      spec_map   <= spec_nxt;
      commit_map <= commit_nxt;
      claimed    <= claimed_nxt;
      free_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_rename_map_unit.sv
// Purpose: self-checking bench for rename_map_unit against a map/free-set reference model.
// Latency: checks combinational outputs each cycle before the edge, then advances the model.
// Backpressure: random alloc requests drop out whenever the model predicts no free register.
module tb_rename_map_unit;
  import rename_pkg::*;

  localparam int AR = ARCH_REGS_DEF;
  localparam int PR = PHYS_REGS_DEF;

  logic                clk = 1'b0;
  logic                rst;
  logic                ena;
  logic [1:0][2:0]     read_arch;
  logic [1:0]          read_ena_in;
  logic [1:0][3:0]     read_phys;
  logic [1:0]          read_ena_out;
  logic                alloc_valid;
  arch_idx_t           alloc_arch;
  logic                alloc_ready;
  phys_idx_t           alloc_phys;
  phys_idx_t           alloc_old_phys;
  logic                retire_valid;
  arch_idx_t           retire_arch;
  phys_idx_t           retire_phys;
  phys_idx_t           retire_old_phys;
  logic                flush;
  logic [4:0]          free_count;

  rename_map_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .read_arch       (read_arch),
    .read_ena_in     (read_ena_in),
    .read_phys       (read_phys),
    .read_ena_out    (read_ena_out),
    .alloc_valid     (alloc_valid),
    .alloc_arch      (alloc_arch),
    .alloc_ready     (alloc_ready),
    .alloc_phys      (alloc_phys),
    .alloc_old_phys  (alloc_old_phys),
    .retire_valid    (retire_valid),
    .retire_arch     (retire_arch),
    .retire_phys     (retire_phys),
    .retire_old_phys (retire_old_phys),
    .flush           (flush),
    .free_count      (free_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain arrays of mappings plus a set of in-use registers.
  int m_spec[AR];
  int m_commit[AR];
  bit m_used[PR];
  int m_free;

  typedef struct { int arch; int phys; int old; } rob_t;
  rob_t rob[$];
  bit   use_rob = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < AR; a++) begin
      m_spec[a]   = a;
      m_commit[a] = a;
    end
    for (int p = 0; p < PR; p++) m_used[p] = (p < AR);
    m_free = PR - AR;
    rob.delete();
  endtask

  task automatic idle();
    rst = 0; ena = 1; flush = 0;
    alloc_valid = 0; alloc_arch = '0;
    retire_valid = 0; retire_arch = '0; retire_phys = '0; retire_old_phys = '0;
    read_ena_in = '0; read_arch = '0;
  endtask

  // Called just after a negedge with inputs applied; checks outputs, then advances one edge.
  task automatic tick();
    int  low;
    bit  any_free;
    bit  rdy;
    bit  take;
    bit  fire;
    int  old;
    #1;
    low = 0;
    any_free = 0;
    for (int p = 0; p < PR; p++) begin
      if (!m_used[p]) begin
        low = p;
        any_free = 1;
        break;
      end
    end
    rdy  = any_free && !flush;
    take = alloc_valid && rdy;
    fire = take && ena;
    old  = m_spec[alloc_arch];
    chk("alloc_ready", 32'(alloc_ready), 32'(rdy));
    chk("alloc_phys", 32'(alloc_phys), take ? low : 0);
    chk("alloc_old_phys", 32'(alloc_old_phys), take ? old : 0);
    chk("read_phys0", 32'(read_phys[0]), read_ena_in[0] ? m_spec[read_arch[0]] : 0);
    chk("read_phys1", 32'(read_phys[1]), read_ena_in[1] ? m_spec[read_arch[1]] : 0);
    chk("read_ena_out", 32'(read_ena_out), 32'(read_ena_in));
    chk("free_count", 32'(free_count), m_free);

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (flush) begin
      if (retire_valid) m_commit[retire_arch] = int'(retire_phys);
      m_spec = m_commit;
      for (int p = 0; p < PR; p++) m_used[p] = 0;
      for (int a = 0; a < AR; a++) m_used[m_commit[a]] = 1;
      m_free = 0;
      for (int p = 0; p < PR; p++) if (!m_used[p]) m_free++;
      rob.delete();
    end else begin
      if (retire_valid) begin
        chk("retire_legal", 32'(m_used[retire_old_phys]), 32'd1);
        m_used[retire_old_phys] = 0;
        m_free++;
        m_commit[retire_arch] = int'(retire_phys);
        if (use_rob && rob.size() > 0) void'(rob.pop_front());
      end
      if (fire) begin
        m_used[low] = 1;
        m_spec[alloc_arch] = low;
        m_free--;
        rob.push_back('{int'(alloc_arch), low, old});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0;

    // Reset state, then fill the free list in order.
    #1;
    chk("reset_free_count", 32'(free_count), 32'd8);
    chk("reset_ready", 32'(alloc_ready), 32'd1);
    for (int i = 0; i < AR; i++) begin
      alloc_valid = 1; alloc_arch = 3'(i);
      #1;
      chk("fill_phys", 32'(alloc_phys), 32'(8 + i));
      chk("fill_old", 32'(alloc_old_phys), 32'(i));
      tick();
    end
    alloc_arch = 3'd0;
    #1;
    chk("empty_count", 32'(free_count), 32'd0);
    chk("empty_ready", 32'(alloc_ready), 32'd0);
    tick();

    // Retire frees p5 while the list is empty: the allocation waits a cycle.
    alloc_valid = 1; alloc_arch = 3'd6;
    retire_valid = 1; retire_arch = 3'd5; retire_phys = 4'd13; retire_old_phys = 4'd5;
    #1;
    chk("stall_ready", 32'(alloc_ready), 32'd0);
    tick();
    retire_valid = 0;
    #1;
    chk("freed_phys", 32'(alloc_phys), 32'd5);
    chk("freed_count", 32'(free_count), 32'd1);
    tick();
    #1;
    chk("refill_count", 32'(free_count), 32'd0);

    // Reset overrides a pending stall and a flush.
    flush = 1; rst = 1;
    tick();
    idle();
    read_ena_in = 2'b11; read_arch[0] = 3'd6; read_arch[1] = 3'd5;
    #1;
    chk("rst_count", 32'(free_count), 32'd8);
    chk("rst_map6", 32'(read_phys[0]), 32'd6);
    chk("rst_map5", 32'(read_phys[1]), 32'd5);
    tick();

    // Source equal to destination sees the old mapping.
    idle();
    alloc_valid = 1; alloc_arch = 3'd3;
    read_ena_in = 2'b01; read_arch[0] = 3'd3; read_arch[1] = 3'd3;
    #1;
    chk("bypass_old", 32'(read_phys[0]), 32'd3);
    chk("bypass_dis", 32'(read_phys[1]), 32'd0);
    tick();
    alloc_valid = 0;
    #1;
    chk("bypass_new", 32'(read_phys[0]), 32'd8);
    tick();

    // Two renames, retire the first, then flush.
    idle(); rst = 1; tick(); idle();
    alloc_valid = 1; alloc_arch = 3'd1; tick();
    alloc_arch = 3'd2; tick();
    idle();
    retire_valid = 1; retire_arch = 3'd1; retire_phys = 4'd8; retire_old_phys = 4'd1;
    tick();
    idle();
    flush = 1; alloc_valid = 1; alloc_arch = 3'd4;
    #1;
    chk("flush_ready", 32'(alloc_ready), 32'd0);
    tick();
    idle();
    read_ena_in = 2'b11; read_arch[0] = 3'd1; read_arch[1] = 3'd2;
    alloc_valid = 1; alloc_arch = 3'd4;
    #1;
    chk("flush_map1", 32'(read_phys[0]), 32'd8);
    chk("flush_map2", 32'(read_phys[1]), 32'd2);
    chk("flush_low", 32'(alloc_phys), 32'd1);
    tick();

    // Flush together with a retire of arch 2.
    idle(); rst = 1; tick(); idle();
    alloc_valid = 1; alloc_arch = 3'd1; tick();
    alloc_arch = 3'd2; tick();
    idle();
    flush = 1;
    retire_valid = 1; retire_arch = 3'd2; retire_phys = 4'd9; retire_old_phys = 4'd2;
    tick();
    idle();
    read_ena_in = 2'b11; read_arch[0] = 3'd2; read_arch[1] = 3'd1;
    alloc_valid = 1; alloc_arch = 3'd0;
    #1;
    chk("fr_map2", 32'(read_phys[0]), 32'd9);
    chk("fr_map1", 32'(read_phys[1]), 32'd1);
    chk("fr_low", 32'(alloc_phys), 32'd2);
    tick();

    // Randomized traffic with in-order retirement from a model ROB.
    idle(); rst = 1; tick();
    use_rob = 1;
    for (int n = 0; n < 800; n++) begin
      idle();
      rst         = ($urandom_range(0, 249) == 0);
      flush       = ($urandom_range(0, 29) == 0);
      ena         = ($urandom_range(0, 7) != 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_arch  = 3'($urandom);
      read_ena_in = 2'($urandom);
      read_arch   = 6'($urandom);
      if (rob.size() > 0 && $urandom_range(0, 1) == 1) begin
        retire_valid    = 1;
        retire_arch     = 3'(rob[0].arch);
        retire_phys     = 4'(rob[0].phys);
        retire_old_phys = 4'(rob[0].old);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
